pipe_stage_skid_reg: RTL



---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_data_slot.sv | 34 +++
 rtl/pipe_stage_skid_reg.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: the occupancy state
// encoding and the default instruction value used for bubbles.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] PIPE_NOP_VAL = 32'h0000_0000;

endpackage

// File: rtl/pipe_data_slot.sv
// One instruction+PC holding register. Reset or clear loads the bubble
// value; clear has priority over load so a flush always wins.
module pipe_data_slot #(
  parameter int               INSTR_W = 32,
  parameter int               PC_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);

  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_instr <= NOP_VAL;
      r_pc    <= '0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is a pure register output and never depends on
// out_ready in the same cycle, and out_* never depends on in_* combinationally.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W = 32,
  parameter int                 PC_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_VAL = INSTR_W'(PIPE_NOP_VAL),
  parameter int                 CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   stall_cnt,
  output pipe_state_e        dbg_state
);

  pipe_state_e        r_state;
  pipe_state_e        w_state_nxt;
  logic               r_in_ready;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_main_load;
  logic               w_skid_load;
  logic               w_main_from_skid;
  logic [INSTR_W-1:0] w_main_d_instr;
  logic [PC_W-1:0]    w_main_d_pc;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc;

  assign out_valid  = (r_state != EMPTY);
  assign in_ready   = r_in_ready;
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign dbg_state  = r_state;
  assign stall_cnt  = r_stall_cnt;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_skid_load      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = BUSY;
          w_main_load = 1'b1;
        end
      end
      BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_load = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt = FULL;
          w_skid_load = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_xfer) begin
          w_state_nxt      = BUSY;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush drops everything, including an input accepted this cycle.
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  // Counter survives flush so stalls around branches remain visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign w_main_d_instr = w_main_from_skid ? w_skid_instr : in_instr;
  assign w_main_d_pc    = w_main_from_skid ? w_skid_pc    : in_pc;

  pipe_data_slot #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (flush),
    .i_load  (w_main_load),
    .i_instr (w_main_d_instr),
    .i_pc    (w_main_d_pc),
    .o_instr (out_instr),
    .o_pc    (out_pc)
  );

  pipe_data_slot #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W),
    .NOP_VAL (NOP_VAL)
  ) u_skid (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (flush),
    .i_load  (w_skid_load),
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

endmodule
